// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the byte-serial AES-128 decryption core.
package aes_pkg;

  localparam logic [4:0] NB_BYTES = 5'd16;
  localparam logic [3:0] NR       = 4'd10;

  typedef enum logic [2:0] {IDLE, KEXP, ARK, ISUB, FIN} state_t;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Byte k is {column,row}; InvShiftRows pulls row r from column c-r (mod 4).
  function automatic logic [3:0] inv_shift_src(input logic [3:0] k);
    return {k[3:2] - k[1:0], k[1:0]};
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] x, input logic [3:0] k);
    return x[8*(15-int'(k)) +: 8];
  endfunction

endpackage

// File: rtl/aes_inv_mixcol.sv
// InvMixColumns on one 32-bit column; byte 0 of the column sits in [31:24].
module aes_inv_mixcol
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col;

  assign mixed = {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                  gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                  gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                  gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};

endmodule

// File: rtl/aes_v3_dec.sv
// Byte-serial AES-128 decryption core using external registered S-box / inverse S-box ROMs.
// Optional key-schedule reuse is enabled by defining AES_DEC_KEYCACHE_EN.
module aes_v3_dec
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [7:0]   sbox_addr,
  input  logic [7:0]   sbox_data,
  output logic [7:0]   isbox_addr,
  input  logic [7:0]   isbox_data,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);

  state_t       cur, nxt;
  logic [4:0]   cnt;
  logic [3:0]   rnd;
  logic [127:0] st, sub_buf;
  logic [127:0] rk [0:10];
  logic [7:0]   sub0, sub1, sub2;
  logic         key_hit;
  logic [127:0] rk_prev, rk_new, ark_fin, mix_out;
  logic [31:0]  temp, w0, w1, w2, w3;

`ifdef AES_DEC_KEYCACHE_EN
  logic key_valid;

  assign key_hit = key_valid && (key == rk[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      key_valid <= 1'b0;
    else if (cur == IDLE && start && !key_hit)
      key_valid <= 1'b0;
    else if (cur == KEXP && cnt == 5'd4 && rnd == NR)
      key_valid <= 1'b1;
  end
`else
  assign key_hit = 1'b0;
`endif

  assign busy = (cur != IDLE) || done;

  // Next round key: SubWord(RotWord(w[4i-1])) arrives as sub0..sub2 plus the live ROM byte.
  assign rk_prev = rk[(rnd == 4'd0) ? 4'd0 : rnd - 4'd1];
  assign temp    = {sub0 ^ rcon(rnd), sub1, sub2, sbox_data};
  assign w0      = rk_prev[127:96] ^ temp;
  assign w1      = rk_prev[95:64]  ^ w0;
  assign w2      = rk_prev[63:32]  ^ w1;
  assign w3      = rk_prev[31:0]   ^ w2;
  assign rk_new  = {w0, w1, w2, w3};

  assign ark_fin = sub_buf ^ rk[rnd];

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_inv_mixcol u_mix (
      .col  (ark_fin[127-32*c -: 32]),
      .mixed(mix_out[127-32*c -: 32])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt        = cur;
    sbox_addr  = 8'h00;
    isbox_addr = 8'h00;
    case (cur)
      IDLE: if (start) nxt = key_hit ? ARK : KEXP;
      KEXP: begin
        if (cnt < 5'd4) sbox_addr = get_byte(rk_prev, {2'b11, cnt[1:0] + 2'd1});
        if (cnt == 5'd4 && rnd == NR) nxt = ARK;
      end
      ARK:  nxt = ISUB;
      ISUB: begin
        if (cnt < NB_BYTES) isbox_addr = get_byte(st, inv_shift_src(cnt[3:0]));
        if (cnt == NB_BYTES) nxt = FIN;
      end
      FIN:  nxt = (rnd == 4'd0) ? IDLE : ISUB;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rnd       <= '0;
      st        <= '0;
      sub_buf   <= '0;
      sub0      <= '0;
      sub1      <= '0;
      sub2      <= '0;
      plaintext <= '0;
      done      <= 1'b0;
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (cur)
        IDLE: if (start) begin
          st  <= ciphertext;
          cnt <= '0;
          rnd <= 4'd1;
          if (!key_hit) rk[0] <= key;
        end
        KEXP: begin
          case (cnt)
            5'd1: sub0 <= sbox_data;
            5'd2: sub1 <= sbox_data;
            5'd3: sub2 <= sbox_data;
            5'd4: begin
              rk[rnd] <= rk_new;
              if (rnd != NR) rnd <= rnd + 4'd1;
            end
            default: ;
          endcase
          cnt <= (cnt == 5'd4) ? 5'd0 : cnt + 5'd1;
        end
        ARK: begin
          st  <= st ^ rk[NR];
          rnd <= NR - 4'd1;
          cnt <= '0;
        end
        // Substituted bytes land in a separate buffer so later InvShiftRows reads see the round input.
        ISUB: begin
          if (cnt != 5'd0) sub_buf[8*(16-int'(cnt)) +: 8] <= isbox_data;
          cnt <= (cnt == NB_BYTES) ? 5'd0 : cnt + 5'd1;
        end
        FIN: begin
          cnt <= '0;
          if (rnd != 4'd0) begin
            st  <= mix_out;
            rnd <= rnd - 4'd1;
          end else begin
            st        <= ark_fin;
            plaintext <= ark_fin;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_v3_dec.sv
// Self-checking bench for aes_v3_dec: ROM models plus a forward AES-128 reference (encrypt-then-decrypt).
module tb_aes_v3_dec;

`ifdef AES_DEC_KEYCACHE_EN
  localparam bit KEYCACHE = 1'b1;
`else
  localparam bit KEYCACHE = 1'b0;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] SECRET = 128'h546869734973415365637265744b6579;
  localparam int NVEC = 12;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  logic         clk, rst, start, done, busy;
  logic [127:0] ciphertext, key, plaintext;
  logic [7:0]   sbox_addr, sbox_data, isbox_addr, isbox_data;

  logic [7:0]   sbox_tab  [256];
  logic [7:0]   isbox_tab [256];
  vec_t         vecs [NVEC];
  int           checks, passes;
  bit           cache_valid;
  logic [127:0] cache_key;

  aes_v3_dec dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ciphertext(ciphertext),
    .key       (key),
    .sbox_addr (sbox_addr),
    .sbox_data (sbox_data),
    .isbox_addr(isbox_addr),
    .isbox_data(isbox_data),
    .plaintext (plaintext),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    sbox_data  <= sbox_tab[sbox_addr];
    isbox_data <= isbox_tab[isbox_addr];
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_tab[x]  = s;
      isbox_tab[s] = 8'(x);
    end
  endtask

  // Textbook forward cipher; the bench decrypts its output through the DUT.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]], sbox_tab[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int b = 0; b < 16; b++) s[b] = sbox_tab[s[b]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int b = 0; b < 16; b++) s[b] = t[b];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rnd + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int exp_lat(input logic [127:0] k);
    return (KEYCACHE && cache_valid && k == cache_key) ? 182 : 232;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, req);
  endtask

  // Presents start for one cycle; returns #1 after the sampling edge (edge 0, start is cycle 0).
  task automatic issue(input logic [127:0] k, input logic [127:0] c);
    start = 1'b1; key = k; ciphertext = c;
    @(posedge clk); #1;
    start = 1'b0; key = rand128(); ciphertext = rand128();
  endtask

  // base = edges already elapsed since edge 0; lat = cycle index in which done is seen.
  task automatic wait_done(input int base, output int lat, output bit got);
    got = 1'b0; lat = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        lat = base + n + 1;
        break;
      end
    end
  endtask

  task automatic finish_op(input string nm, input vec_t v, input int want, input int lat, input bit got);
    check({nm, "_done_seen"}, 128'(got), 128'(1));
    check({nm, "_plaintext"}, plaintext, v.pt);
    check({nm, "_latency"}, 128'(lat), 128'(want));
    check({nm, "_busy_at_done"}, 128'(busy), 128'(1));
    if (got) begin
      cache_valid = 1'b1;
      cache_key   = v.key;
    end
  endtask

  initial begin
    int   lat, want, ndone;
    bit   got;
    vec_t v;

    checks = 0; passes = 0;
    cache_valid = 1'b0; cache_key = '0;
    rst = 1'b1; start = 1'b0; key = '0; ciphertext = '0;
    build_tables();
    repeat (3) @(posedge clk);
    #1;
    check("reset_plaintext", plaintext, 128'h0);
    check("reset_done", 128'(done), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_sbox_addr", 128'(sbox_addr), 128'(0));
    check("reset_isbox_addr", 128'(isbox_addr), 128'(0));
    @(negedge clk) rst = 1'b0;

    vecs[0] = '{C1_KEY, C1_CT, C1_PT};
    vecs[1] = '{C1_KEY, C1_CT, C1_PT};
    vecs[2] = '{B_KEY, B_CT, B_PT};
    for (int i = 3; i < 6; i++) begin
      vecs[i].key = rand128();
      vecs[i].pt  = rand128();
      vecs[i].ct  = aes_enc(vecs[i].pt, vecs[i].key);
    end
    for (int i = 6; i < NVEC; i++) begin
      vecs[i].key = SECRET;
      vecs[i].pt  = rand128();
      vecs[i].ct  = aes_enc(vecs[i].pt, SECRET);
    end

    // All table entries run back-to-back: each start is raised in the previous done cycle.
    @(negedge clk);
    want = exp_lat(vecs[0].key);
    issue(vecs[0].key, vecs[0].ct);
    for (int i = 0; i < NVEC; i++) begin
      wait_done(0, lat, got);
      v = vecs[i];
      finish_op($sformatf("vec%0d", i), v, want, lat, got);
      if (i + 1 < NVEC) begin
        want = exp_lat(vecs[i+1].key);
        issue(vecs[i+1].key, vecs[i+1].ct);
      end
    end
    @(posedge clk); #1;
    check("done_single_pulse", 128'(done), 128'(0));
    check("busy_after_done", 128'(busy), 128'(0));

    // A second start in the middle of an operation must be ignored.
    @(negedge clk);
    want = exp_lat(C1_KEY);
    issue(C1_KEY, C1_CT);
    repeat (99) @(posedge clk);
    #1;
    start = 1'b1; key = B_KEY; ciphertext = B_CT;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, lat, got);
    finish_op("ignored_start", '{C1_KEY, C1_CT, C1_PT}, want, lat, got);

    // Reset in cycle 120 aborts the operation and clears the outputs.
    @(negedge clk);
    issue(B_KEY, B_CT);
    repeat (119) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    cache_valid = 1'b0;
    check("abort_plaintext", plaintext, 128'h0);
    check("abort_done", 128'(done), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_sbox_addr", 128'(sbox_addr), 128'(0));
    check("abort_isbox_addr", 128'(isbox_addr), 128'(0));
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", 128'(ndone), 128'(0));

    @(negedge clk);
    want = exp_lat(C1_KEY);
    issue(C1_KEY, C1_CT);
    check("kexp_first_sbox_addr", 128'(sbox_addr), 128'(8'h0d));
    check("busy_after_start", 128'(busy), 128'(1));
    wait_done(0, lat, got);
    finish_op("post_reset_c1", '{C1_KEY, C1_CT, C1_PT}, want, lat, got);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
